snn_membrane_bank: RTL and testbench
====================================

# snn_membrane_bank

Time-multiplexed leaky integrate-and-fire membrane store for `NEURONS` neurons. It sits directly around the combinational `batch_normalization` stage. It drives the stored, leaked membrane potential and the incoming weighted sum `z` into that stage, and consumes the normalized result. It then thresholds the result, emits one spike bit per update, and writes the post-spike membrane back. It processes one neuron update per cycle behind a valid/ready handshake.

## Interface
- `WIDTH`, 6: signed membrane/input width; must match `batch_normalization` `WIDTH`.
- `NEURONS`, 4: number of neurons stored.
- `IDX_W`, `$clog2(NEURONS)`: neuron index width.
- `clk` input 1: the only clock.
- `rst_n` input 1: asynchronous, active-low reset.
- `clear` input 1: synchronous zeroing of all membranes, asserted at time-step start.
- `threshold` input `WIDTH`: signed firing threshold; legal range 1..MAX_VALUE.
- `leak_sel` input 2: per-update leak, applied before normalization. 0 = none, k = `u - (u>>>k)`.
- `in_valid` input 1, `in_ready` output 1: input handshake.
- `in_idx` input `IDX_W`: neuron to update; values ≥ `NEURONS` are ignored (accepted, no write, no output).
- `in_z` input `WIDTH`: signed weighted sum for that neuron.
- `u_to_bn` output `WIDTH`, `z_to_bn` output `WIDTH`: drive `batch_normalization.u`/`.z`.
- `u_from_bn` input `WIDTH`: `batch_normalization.u_out`, already saturated.
- `out_valid` output 1, `out_ready` input 1: output handshake.
- `out_idx` output `IDX_W`, `out_spike` output 1: neuron index and its spike.
- `out_u` output `WIDTH`: membrane value written back.

## Operation
- Two-stage pipeline: S1 register (`s1_valid`, `s1_idx`, `s1_z`), then output register.
- Accept on `in_valid && in_ready`; S1 captures idx/z.
- S1 combinational path:
  - `u_to_bn = leak(mem[s1_idx], leak_sel)`, `z_to_bn = s1_z`.
  - `spike = (u_from_bn >= threshold)`, signed compare.
  - `u_new = spike ? u_from_bn - threshold : u_from_bn`.
- Leak uses arithmetic shift. Magnitude never grows, so no overflow: −1 → 0, −32 with k=1 → −16.
- Subtraction is in `WIDTH` bits. It cannot overflow, since `u_from_bn ≥ threshold ≥ 1`.
- On advance (`s1_valid && (!out_valid || out_ready)`):
  - write `mem[s1_idx] = u_new`;
  - load the output register;
  - `out_valid = 1`.
- `in_ready = !s1_valid || advance`. S1 stays full while stalled, and `u_to_bn` is held stable.
- Back-to-back updates to the same index need no bypass: the write lands at the edge before the next S1 read.
- `clear`: all `mem` ← 0, `s1_valid` ← 0, `out_valid` ← 0, `in_ready` = 0 that cycle. `clear` beats a simultaneous write-back and acceptance; in-flight updates are discarded.

## Timing
- Reset values: `mem` = 0, `s1_valid` = 0, `out_valid` = 0, `out_idx`/`out_spike`/`out_u` = 0, `in_ready` = 1.
- Reset mid-operation drops all in-flight data immediately (asynchronous).
- Latency: accepted at edge N → `out_valid` high after edge N+1.
- Throughput: 1 update/cycle with `out_ready` held high.
- Output fields are stable while `out_valid && !out_ready`.

## Configuration
- `MEMBRANE_RESET_TO_ZERO_EN`:
  - Defined: a spike writes `u_new = 0`, and `out_u` = 0.
  - Undefined (default): reset-by-subtraction as above.

## Structure
- Shared package `snn_pkg`: `WIDTH` default, `MAX_VALUE`/`MIN_VALUE` constants, leak encoding constants `LEAK_NONE`, `LEAK_HALF`, `LEAK_QUARTER`, `LEAK_EIGHTH`.
- One sub-module: `membrane_leak` (combinational, `u`, `leak_sel` → leaked `u`).
- `batch_normalization` stays external and is connected by the parent.

## Test plan
Bench wires a real `batch_normalization` with `BN_factor=4'b0100`, `BN_addend=0` (u+z), threshold 16, and `leak_sel=0` unless stated.
- Reset, then idx0 z=10 twice → out (0,spike0,u10), then (0,spike1,u4); `mem[0]`=4.
- idx1 z=20 → spike1, u4; set leak_sel=1, then idx1 z=0 → `u_to_bn`=2, out (1,spike0,u2).
- Saturation: idx2 z=31 with mem 0, then z=31 → u_from_bn=31 (saturated), spike1, u15; with `MEMBRANE_RESET_TO_ZERO_EN`, u0.
- Backpressure: `out_ready`=0 with three inputs offered → one output held, S1 holds one, `in_ready`=0. Release → outputs in order, no loss or duplication.
- `clear` in the same cycle as an advance → no output, all `mem` read back 0 via z=0 updates.
- `rst_n` low mid-stream, then release → `out_valid`=0, `in_ready`=1, `mem` all 0; `in_idx`=5 with NEURONS=4 → accepted, no output.

Source files
------------

// File: rtl/snn_pkg.sv
// Shared constants and leak encodings for the spiking-network datapath.
package snn_pkg;

    localparam int WIDTH_DEFAULT = 6;
    localparam int MAX_VALUE     = (2 ** (WIDTH_DEFAULT - 1)) - 1;
    localparam int MIN_VALUE     = -(2 ** (WIDTH_DEFAULT - 1));

    typedef enum logic [1:0] {
        LEAK_NONE    = 2'd0,
        LEAK_HALF    = 2'd1,
        LEAK_QUARTER = 2'd2,
        LEAK_EIGHTH  = 2'd3
    } leak_e;

endpackage

// File: rtl/snn_membrane_bank_if.sv
// Update request / result handshake bundle for snn_membrane_bank.
interface snn_membrane_bank_if
    import snn_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT,
    parameter int IDX_W = 2
);
    logic                    in_valid;
    logic                    in_ready;
    logic [IDX_W-1:0]        in_idx;
    logic signed [WIDTH-1:0] in_z;

    logic                    out_valid;
    logic                    out_ready;
    logic [IDX_W-1:0]        out_idx;
    logic                    out_spike;
    logic signed [WIDTH-1:0] out_u;

    modport master (
        output in_valid, in_idx, in_z, out_ready,
        input  in_ready, out_valid, out_idx, out_spike, out_u
    );

    modport slave (
        input  in_valid, in_idx, in_z, out_ready,
        output in_ready, out_valid, out_idx, out_spike, out_u
    );
endinterface

// File: rtl/batch_normalization.sv
// Combinational normalization stage: sat(((u + z) * BN_factor) / 4 + BN_addend), BN_factor in Q2.2.
module batch_normalization #(
    parameter int WIDTH = 6
) (
    input  logic signed [WIDTH-1:0] u,
    input  logic signed [WIDTH-1:0] z,
    input  logic        [3:0]       BN_factor,
    input  logic signed [WIDTH-1:0] BN_addend,
    output logic signed [WIDTH-1:0] u_out
);
    localparam int PW = WIDTH + 6;
    localparam logic signed [PW-1:0] MAXV = PW'((2 ** (WIDTH - 1)) - 1);
    localparam logic signed [PW-1:0] MINV = PW'(-(2 ** (WIDTH - 1)));

    logic signed [WIDTH:0]  sum;
    logic signed [PW-1:0]   prod;
    logic signed [PW-1:0]   scaled;

    always_comb begin
        sum    = {u[WIDTH-1], u} + {z[WIDTH-1], z};
        prod   = PW'(sum) * PW'($signed({1'b0, BN_factor}));
        scaled = (prod >>> 2) + PW'(BN_addend);
        if (scaled > MAXV) begin
            u_out = MAXV[WIDTH-1:0];
        end else if (scaled < MINV) begin
            u_out = MINV[WIDTH-1:0];
        end else begin
            u_out = scaled[WIDTH-1:0];
        end
    end
endmodule

// File: rtl/membrane_leak.sv
// Combinational membrane leak: u - (u >>> k); arithmetic shift so magnitude never grows.
module membrane_leak
    import snn_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic signed [WIDTH-1:0] u,
    input  logic        [1:0]       leak_sel,
    output logic signed [WIDTH-1:0] u_leaked
);
    always_comb begin
        u_leaked = u;
        case (leak_sel)
            LEAK_HALF:    u_leaked = u - (u >>> 1);
            LEAK_QUARTER: u_leaked = u - (u >>> 2);
            LEAK_EIGHTH:  u_leaked = u - (u >>> 3);
            default:      u_leaked = u;
        endcase
    end
endmodule

// File: rtl/snn_membrane_bank.sv
// Time-multiplexed LIF membrane store around an external batch_normalization stage.
// Define MEMBRANE_RESET_TO_ZERO_EN to zero the membrane on a spike instead of subtracting threshold.
module snn_membrane_bank
    import snn_pkg::*;
#(
    parameter int WIDTH   = WIDTH_DEFAULT,
    parameter int NEURONS = 4,
    parameter int IDX_W   = $clog2(NEURONS)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clear,
    input  logic signed [WIDTH-1:0] threshold,
    input  logic        [1:0]       leak_sel,
    output logic signed [WIDTH-1:0] u_to_bn,
    output logic signed [WIDTH-1:0] z_to_bn,
    input  logic signed [WIDTH-1:0] u_from_bn,
    snn_membrane_bank_if.slave      bus
);
    logic signed [WIDTH-1:0] mem [NEURONS];

    logic                    s1_valid;
    logic [IDX_W-1:0]        s1_idx;
    logic signed [WIDTH-1:0] s1_z;

    logic signed [WIDTH-1:0] mem_rd;
    logic signed [WIDTH-1:0] u_new;
    logic                    spike;
    logic                    advance;
    logic                    accept;
    logic                    in_idx_ok;

    // Index decode by comparison so out-of-range indices read zero instead of walking off the array.
    always_comb begin
        mem_rd = '0;
        for (int i = 0; i < NEURONS; i++) begin
            if (s1_idx == IDX_W'(i)) begin
                mem_rd = mem[i];
            end
        end
    end

    membrane_leak #(.WIDTH(WIDTH)) u_leak (
        .u        (mem_rd),
        .leak_sel (leak_sel),
        .u_leaked (u_to_bn)
    );

    assign z_to_bn = s1_z;
    assign spike   = (u_from_bn >= threshold);

`ifdef MEMBRANE_RESET_TO_ZERO_EN
    assign u_new = spike ? '0 : u_from_bn;
`else
    assign u_new = spike ? (u_from_bn - threshold) : u_from_bn;
`endif

    assign advance      = s1_valid && (!bus.out_valid || bus.out_ready);
    assign bus.in_ready = !clear && (!s1_valid || advance);
    assign accept       = bus.in_valid && bus.in_ready;
    assign in_idx_ok    = (int'(bus.in_idx) < NEURONS);

    // Write-back lands before the next S1 read, so same-index back-to-back needs no bypass.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NEURONS; i++) begin
                mem[i] <= '0;
            end
        end else if (clear) begin
            for (int i = 0; i < NEURONS; i++) begin
                mem[i] <= '0;
            end
        end else if (advance) begin
            for (int i = 0; i < NEURONS; i++) begin
                if (s1_idx == IDX_W'(i)) begin
                    mem[i] <= u_new;
                end
            end
        end
    end

    // Out-of-range indices are consumed here but never become valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_idx   <= '0;
            s1_z     <= '0;
        end else if (clear) begin
            s1_valid <= 1'b0;
        end else if (accept) begin
            s1_valid <= in_idx_ok;
            s1_idx   <= bus.in_idx;
            s1_z     <= bus.in_z;
        end else if (advance) begin
            s1_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.out_valid <= 1'b0;
            bus.out_idx   <= '0;
            bus.out_spike <= 1'b0;
            bus.out_u     <= '0;
        end else if (clear) begin
            bus.out_valid <= 1'b0;
        end else if (advance) begin
            bus.out_valid <= 1'b1;
            bus.out_idx   <= s1_idx;
            bus.out_spike <= spike;
            bus.out_u     <= u_new;
        end else if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_snn_membrane_bank.sv
// Randomized + directed bench for snn_membrane_bank against a queue-based LIF reference model.
module tb_snn_membrane_bank;
    import snn_pkg::*;

    localparam int W  = 6;
    localparam int N  = 4;
    localparam int IW = 3;

    typedef struct {
        int idx;
        int spike;
        int u;
    } exp_t;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                clear = 1'b0;
    logic signed [W-1:0] threshold = 6'sd16;
    logic        [1:0]   leak_sel = 2'd0;
    logic signed [W-1:0] u_to_bn;
    logic signed [W-1:0] z_to_bn;
    logic signed [W-1:0] u_from_bn;

    int   checks = 0;
    int   failures = 0;
    int   mdl_mem [N];
    exp_t exp_q [$];
    int   last_idx = -1;
    int   last_spike = -1;
    int   last_u = -99;

    snn_membrane_bank_if #(.WIDTH(W), .IDX_W(IW)) bus ();

    always #5 clk = ~clk;

    snn_membrane_bank #(.WIDTH(W), .NEURONS(N), .IDX_W(IW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear),
        .threshold (threshold),
        .leak_sel  (leak_sel),
        .u_to_bn   (u_to_bn),
        .z_to_bn   (z_to_bn),
        .u_from_bn (u_from_bn),
        .bus       (bus.slave)
    );

    batch_normalization #(.WIDTH(W)) bn (
        .u         (u_to_bn),
        .z         (z_to_bn),
        .BN_factor (4'b0100),
        .BN_addend (6'sd0),
        .u_out     (u_from_bn)
    );

    task automatic checkOutput(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int sat_model(int v);
        if (v > 31) return 31;
        if (v < -32) return -32;
        return v;
    endfunction

    // Leak as u minus floor(u / 2^k), written with plain integer division.
    function automatic int leak_model(int u, int k);
        int d;
        int step;
        if (k == 0) return u;
        d = 1 << k;
        step = (u >= 0) ? (u / d) : -((-u + d - 1) / d);
        return u - step;
    endfunction

    function automatic exp_t model_update(int idx, int z);
        exp_t e;
        int bnv;
        int thr;
        thr = int'(threshold);
        bnv = sat_model(leak_model(mdl_mem[idx], int'(leak_sel)) + z);
        e.idx = idx;
        e.spike = (bnv >= thr) ? 1 : 0;
`ifdef MEMBRANE_RESET_TO_ZERO_EN
        e.u = e.spike ? 0 : bnv;
`else
        e.u = e.spike ? (bnv - thr) : bnv;
`endif
        mdl_mem[idx] = e.u;
        return e;
    endfunction

    function automatic void model_flush();
        exp_q.delete();
        for (int i = 0; i < N; i++) mdl_mem[i] = 0;
    endfunction

    // One cycle: drive at negedge, sample #1 later, predict what the next posedge does.
    task automatic applyStimulus(input logic v, input int idx, input int z,
                                 input logic ordy, input logic clr);
        exp_t e;
        @(negedge clk);
        bus.in_valid  = v;
        bus.in_idx    = IW'(idx);
        bus.in_z      = W'(z);
        bus.out_ready = ordy;
        clear         = clr;
        #1;
        if (bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                checkOutput("unexpected_out", 1, 0);
            end else begin
                e = exp_q.pop_front();
                checkOutput("out_idx", int'(bus.out_idx), e.idx);
                checkOutput("out_spike", int'(bus.out_spike), e.spike);
                checkOutput("out_u", int'(bus.out_u), e.u);
                last_idx   = int'(bus.out_idx);
                last_spike = int'(bus.out_spike);
                last_u     = int'(bus.out_u);
            end
        end
        if (clr) begin
            checkOutput("in_ready_clear", int'(bus.in_ready), 0);
            model_flush();
        end else if (v && bus.in_ready && idx < N) begin
            exp_q.push_back(model_update(idx, z));
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 0, 0, 1'b1, 1'b0);
        checkOutput("drain_empty", exp_q.size(), 0);
    endtask

    task automatic read_all_zero(input string tag);
        for (int i = 0; i < N; i++) applyStimulus(1'b1, i, 0, 1'b1, 1'b0);
        drain();
        checkOutput(tag, last_u, 0);
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_idx    = '0;
        bus.in_z      = '0;
        bus.out_ready = 1'b1;
        model_flush();
        #1;
        checkOutput("rst_out_valid", int'(bus.out_valid), 0);
        checkOutput("rst_in_ready", int'(bus.in_ready), 1);
        checkOutput("rst_out_idx", int'(bus.out_idx), 0);
        checkOutput("rst_out_spike", int'(bus.out_spike), 0);
        checkOutput("rst_out_u", int'(bus.out_u), 0);
        @(negedge clk);
        rst_n = 1'b1;

        $display("[TB] integrate and subtract-reset on idx0");
        applyStimulus(1'b1, 0, 10, 1'b1, 1'b0);
        applyStimulus(1'b1, 0, 10, 1'b1, 1'b0);
        applyStimulus(1'b0, 0, 0, 1'b1, 1'b0);
        checkOutput("t1_first_u", last_u, 10);
        checkOutput("t1_first_spike", last_spike, 0);
        drain();
        checkOutput("t1_second_u", last_u, 4);
        checkOutput("t1_second_spike", last_spike, 1);

        $display("[TB] leak on idx1");
        applyStimulus(1'b1, 1, 20, 1'b1, 1'b0);
        drain();
        checkOutput("t2_spike_u", last_u, 4);
        leak_sel = 2'd1;
        applyStimulus(1'b1, 1, 0, 1'b1, 1'b0);
        applyStimulus(1'b0, 0, 0, 1'b1, 1'b0);
        checkOutput("t2_u_to_bn", int'(u_to_bn), 2);
        drain();
        checkOutput("t2_leak_u", last_u, 2);
        checkOutput("t2_leak_idx", last_idx, 1);
        leak_sel = 2'd0;

        $display("[TB] saturation on idx2");
        applyStimulus(1'b1, 2, 31, 1'b1, 1'b0);
        applyStimulus(1'b1, 2, 31, 1'b1, 1'b0);
        applyStimulus(1'b0, 0, 0, 1'b1, 1'b0);
        checkOutput("t3_u_from_bn", int'(u_from_bn), 31);
        drain();
        checkOutput("t3_spike", last_spike, 1);
`ifdef MEMBRANE_RESET_TO_ZERO_EN
        checkOutput("t3_u", last_u, 0);
`else
        checkOutput("t3_u", last_u, 15);
`endif

        $display("[TB] backpressure on idx3");
        applyStimulus(1'b1, 3, 5, 1'b0, 1'b0);
        applyStimulus(1'b1, 3, 6, 1'b0, 1'b0);
        applyStimulus(1'b1, 3, 7, 1'b0, 1'b0);
        checkOutput("t4_in_ready_stall", int'(bus.in_ready), 0);
        checkOutput("t4_out_valid_held", int'(bus.out_valid), 1);
        checkOutput("t4_out_u_held", int'(bus.out_u), 5);
        applyStimulus(1'b1, 3, 7, 1'b0, 1'b0);
        checkOutput("t4_out_u_stable", int'(bus.out_u), 5);
        applyStimulus(1'b1, 3, 7, 1'b1, 1'b0);
        drain();
        checkOutput("t4_last_u", last_u, 2);

        $display("[TB] clear against advance");
        applyStimulus(1'b1, 0, 5, 1'b1, 1'b0);
        applyStimulus(1'b0, 0, 0, 1'b1, 1'b1);
        applyStimulus(1'b0, 0, 0, 1'b1, 1'b0);
        checkOutput("t5_no_out", int'(bus.out_valid), 0);
        read_all_zero("t5_mem_zero");

        $display("[TB] async reset mid-stream");
        applyStimulus(1'b1, 1, 9, 1'b1, 1'b0);
        applyStimulus(1'b1, 2, 9, 1'b1, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        bus.in_valid = 1'b0;
        #1;
        checkOutput("t6_rst_out_valid", int'(bus.out_valid), 0);
        checkOutput("t6_rst_in_ready", int'(bus.in_ready), 1);
        model_flush();
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(1'b1, 5, 3, 1'b1, 1'b0);
        checkOutput("t6_bad_idx_ready", int'(bus.in_ready), 1);
        applyStimulus(1'b0, 0, 0, 1'b1, 1'b0);
        applyStimulus(1'b0, 0, 0, 1'b1, 1'b0);
        checkOutput("t6_bad_idx_no_out", int'(bus.out_valid), 0);
        read_all_zero("t6_mem_zero");

        $display("[TB] randomized phases");
        for (int p = 0; p < 4; p++) begin
            threshold = W'(int'($urandom_range(31, 1)));
            leak_sel  = 2'($urandom_range(3));
            for (int c = 0; c < 200; c++) begin
                applyStimulus($urandom_range(3) != 0,
                              int'($urandom_range(4)),
                              int'($urandom_range(63)) - 32,
                              $urandom_range(2) != 0,
                              $urandom_range(39) == 0);
            end
            drain();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
